// File: rtl/bus_drive_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_drive_sequencer_pkg
// Description : Shared encodings for the 6502 data-bus drive sequencer:
//               FSM state codes, grant/owner codes and synchroniser depth.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_drive_sequencer_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_DRIVE  = 2'd2;
    localparam logic [1:0] c_ST_TURN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        SETTLE = c_ST_SETTLE,
        DRIVE  = c_ST_DRIVE,
        TURN   = c_ST_TURN
    } state_t;

    // Grant encoding; the bus owner register uses the same codes so grant
    // can be driven straight from it.
    localparam logic [1:0] c_GNT_NONE = 2'b00;
    localparam logic [1:0] c_GNT_ROM  = 2'b01;
    localparam logic [1:0] c_GNT_IWM  = 2'b10;

    typedef enum logic [1:0] {
        SRC_NONE = c_GNT_NONE,
        SRC_ROM  = c_GNT_ROM,
        SRC_IWM  = c_GNT_IWM
    } src_t;

    // Flops between an asynchronous 6502-side pin and the first use in fclk
    localparam int c_SYNC_STAGES = 2;

    // Larger of two integers, used to size the shared settle/turn counter
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_drive_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// Module      : bus_drive_sequencer_sync2
// Description : Multi-flop synchroniser for one asynchronous bus pin, with a
//               parameterised reset value so inactive-high selects come out
//               of reset deasserted.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_drive_sequencer_sync2
    import bus_drive_sequencer_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [c_SYNC_STAGES-1:0] r_sync;

    // Shift the raw pin through the flop chain; bit 0 is the metastable stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {c_SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[c_SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[c_SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bus_drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bus_drive_sequencer
// Description : Arbitrates the shared 6502 data bus between the slot ROM and
//               the IWM register file. Grants one source at a time, waits a
//               settle delay before enabling the 74x245 / data pins, and
//               holds the bus released for a turnaround gap after every
//               grant so the two sources can never contend. Overlapping
//               requests raise a conflict pulse and bump a saturating count.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_drive_sequencer
    import bus_drive_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int TURN_CYCLES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic             fclk,
    input  logic             reset,
    input  logic             rom_sel_n,
    input  logic             dev_sel_n,
    input  logic             rw,
    input  logic             addr0,
    input  logic [7:0]       rom_data,
    input  logic [7:0]       iwm_data,
    output logic             en245_n,
    output logic             data_oe,
    output logic [7:0]       data_out,
    output logic [1:0]       grant,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    // One counter serves both SETTLE and TURN; it only needs to reach
    // max(SETTLE_CYCLES, TURN_CYCLES) - 1.
    localparam int c_CNT_MAX = max2(SETTLE_CYCLES, TURN_CYCLES);
    localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CW-1:0]  c_SETTLE_LAST = c_CW'(SETTLE_CYCLES - 1);
    localparam logic [c_CW-1:0]  c_TURN_LAST   = c_CW'(TURN_CYCLES - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE     = c_CW'(1);
    localparam logic [CNT_W-1:0] c_CONF_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CONF_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------
    // Synchronised copies of the 6502-side pins
    // ------------------------------------------------------------------
    logic w_rom_sel_n_s;
    logic w_dev_sel_n_s;
    logic w_rw_s;
    logic w_addr0_s;

    bus_drive_sequencer_sync2 #(.RESET_VAL(1'b1)) u_sync_rom_sel (
        .clk (fclk),
        .rst (reset),
        .i_d (rom_sel_n),
        .o_q (w_rom_sel_n_s)
    );

    bus_drive_sequencer_sync2 #(.RESET_VAL(1'b1)) u_sync_dev_sel (
        .clk (fclk),
        .rst (reset),
        .i_d (dev_sel_n),
        .o_q (w_dev_sel_n_s)
    );

    bus_drive_sequencer_sync2 #(.RESET_VAL(1'b0)) u_sync_rw (
        .clk (fclk),
        .rst (reset),
        .i_d (rw),
        .o_q (w_rw_s)
    );

    bus_drive_sequencer_sync2 #(.RESET_VAL(1'b0)) u_sync_addr0 (
        .clk (fclk),
        .rst (reset),
        .i_d (addr0),
        .o_q (w_addr0_s)
    );

    logic w_req_rom;
    logic w_req_iwm;

    assign w_req_rom = ~w_rom_sel_n_s;
    assign w_req_iwm = ~w_dev_sel_n_s;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    src_t              r_src;
    src_t              w_src_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic              w_conflict;
    logic              r_conflict;
    logic [CNT_W-1:0]  r_conflict_cnt;

    // Requests seen from the current owner's point of view
    logic w_own_req;
    logic w_other_req;

    // Map the two synced requests onto owner / competitor for the held source
    always_comb begin
        w_own_req   = 1'b0;
        w_other_req = 1'b0;
        case (r_src)
            SRC_ROM: begin
                w_own_req   = w_req_rom;
                w_other_req = w_req_iwm;
            end
            SRC_IWM: begin
                w_own_req   = w_req_iwm;
                w_other_req = w_req_rom;
            end
            default: begin
                w_own_req   = 1'b0;
                w_other_req = 1'b0;
            end
        endcase
    end

    // Register state, owner, shared counter and the conflict pulse
    always_ff @(posedge fclk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_src      <= SRC_NONE;
            r_cnt      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_src      <= w_src_nxt;
            r_cnt      <= w_cnt_nxt;
            r_conflict <= w_conflict;
        end
    end

    // Next-state logic: grant one requester, settle, drive, then turn around
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_cnt_nxt   = r_cnt;
        w_conflict  = 1'b0;

        case (r_state)
            IDLE: begin
                w_src_nxt = SRC_NONE;
                if (w_req_rom && w_req_iwm) begin
                    // Both selects at once: refuse both, wait for one to clear
                    w_conflict = 1'b1;
                end else if (w_req_rom) begin
                    w_src_nxt   = SRC_ROM;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end else if (w_req_iwm) begin
                    w_src_nxt   = SRC_IWM;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end

            SETTLE: begin
                if (!w_own_req || w_other_req) begin
                    // Request glitched away or a competitor appeared before
                    // we started driving; back off through turnaround.
                    w_conflict  = w_other_req;
                    w_cnt_nxt   = '0;
                    w_state_nxt = TURN;
                end else if (r_cnt == c_SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            DRIVE: begin
                if (!w_own_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = TURN;
                end else if (w_other_req) begin
                    w_conflict  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = TURN;
                end
            end

            TURN: begin
                // Requests are deliberately ignored here; IDLE re-samples them
                if (r_cnt == c_TURN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_src_nxt   = SRC_NONE;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_src_nxt   = SRC_NONE;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Saturating count of conflict pulses, stepped alongside the pulse itself
    always_ff @(posedge fclk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != c_CONF_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + c_CONF_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: only registered state, owner and synced qualifiers
    // ------------------------------------------------------------------
    logic w_driving;

    assign w_driving = (r_state == DRIVE);

    assign en245_n = ~w_driving;

    // Writes still open the 245 so the IWM can latch; only reads drive the
    // pins, and IWM reads only when addr0 is low.
    assign data_oe = w_driving && w_rw_s && !((r_src == SRC_IWM) && w_addr0_s);

    // Live byte mux selected by the current owner
    always_comb begin
        data_out = 8'h00;
        case (r_src)
            SRC_ROM: data_out = rom_data;
            SRC_IWM: data_out = iwm_data;
            default: data_out = 8'h00;
        endcase
    end

    assign grant        = ((r_state == SETTLE) || (r_state == DRIVE)) ? r_src : c_GNT_NONE;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_drive_sequencer
// Description : Self-checking bench for bus_drive_sequencer: a table of
//               directed phases with hand-derived expected outputs, a few
//               hand-written corner sequences, and randomised traffic, all
//               shadowed cycle by cycle by a countdown-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_drive_sequencer;

    localparam int SETTLE_CYCLES = 2;
    localparam int TURN_CYCLES   = 2;
    localparam int CNT_W         = 8;
    localparam int CNT_SAT       = (1 << CNT_W) - 1;

    logic             fclk = 1'b0;
    logic             reset = 1'b1;
    logic             rom_sel_n = 1'b1;
    logic             dev_sel_n = 1'b1;
    logic             rw = 1'b0;
    logic             addr0 = 1'b0;
    logic [7:0]       rom_data = 8'h00;
    logic [7:0]       iwm_data = 8'h00;
    logic             en245_n;
    logic             data_oe;
    logic [7:0]       data_out;
    logic [1:0]       grant;
    logic             conflict;
    logic [CNT_W-1:0] conflict_cnt;

    bus_drive_sequencer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TURN_CYCLES   (TURN_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .fclk         (fclk),
        .reset        (reset),
        .rom_sel_n    (rom_sel_n),
        .dev_sel_n    (dev_sel_n),
        .rw           (rw),
        .addr0        (addr0),
        .rom_data     (rom_data),
        .iwm_data     (iwm_data),
        .en245_n      (en245_n),
        .data_oe      (data_oe),
        .data_out     (data_out),
        .grant        (grant),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    always #5 fclk = ~fclk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: mode 0 idle / 1 settling / 2 driving / 3 turnaround,
    // owner 0 none / 1 ROM / 2 IWM, m_left = cycles remaining in the phase.
    // Pin history: index 1 is the value the sequencer decides on.
    // ------------------------------------------------------------------
    int m_mode;
    int m_owner;
    int m_left;
    int m_cnt;
    bit m_conf;
    bit h_rom[2];
    bit h_dev[2];
    bit h_rw[2];
    bit h_a0[2];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rr, ri, own, oth;
        if (reset) begin
            m_mode = 0; m_owner = 0; m_left = 0; m_cnt = 0; m_conf = 0;
            h_rom = '{1'b1, 1'b1};
            h_dev = '{1'b1, 1'b1};
            h_rw  = '{1'b0, 1'b0};
            h_a0  = '{1'b0, 1'b0};
            return;
        end
        rr  = !h_rom[1];
        ri  = !h_dev[1];
        own = (m_owner == 1) ? rr : ri;
        oth = (m_owner == 1) ? ri : rr;
        m_conf = 0;
        case (m_mode)
            0: begin
                if (rr && ri) m_conf = 1;
                else if (rr || ri) begin
                    m_owner = rr ? 1 : 2;
                    m_mode  = 1;
                    m_left  = SETTLE_CYCLES;
                end
            end
            1: begin
                if (!own || oth) begin
                    m_conf = oth;
                    m_mode = 3;
                    m_left = TURN_CYCLES;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
            end
            2: begin
                if (!own || oth) begin
                    m_conf = own && oth;
                    m_mode = 3;
                    m_left = TURN_CYCLES;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode  = 0;
                    m_owner = 0;
                end
            end
        endcase
        if (m_conf && m_cnt < CNT_SAT) m_cnt++;
        h_rom[1] = h_rom[0]; h_rom[0] = rom_sel_n;
        h_dev[1] = h_dev[0]; h_dev[0] = dev_sel_n;
        h_rw[1]  = h_rw[0];  h_rw[0]  = rw;
        h_a0[1]  = h_a0[0];  h_a0[0]  = addr0;
    endtask

    task automatic check_model();
        bit         drv;
        bit         oe;
        logic [7:0] d;
        logic [1:0] g;
        drv = (m_mode == 2);
        oe  = drv && h_rw[1] && !(m_owner == 2 && h_a0[1]);
        d   = (m_owner == 1) ? rom_data : (m_owner == 2) ? iwm_data : 8'h00;
        g   = (m_mode == 1 || m_mode == 2) ? 2'(m_owner) : 2'b00;
        chk("model en245_n",      16'(en245_n),      16'(!drv));
        chk("model data_oe",      16'(data_oe),      16'(oe));
        chk("model data_out",     16'(data_out),     16'(d));
        chk("model grant",        16'(grant),        16'(g));
        chk("model conflict",     16'(conflict),     16'(m_conf));
        chk("model conflict_cnt", 16'(conflict_cnt), 16'(m_cnt));
    endtask

    // One fclk cycle: model follows the edge, outputs are sampled 1 ns later
    task automatic step();
        @(posedge fclk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic chk_outs(input string tag, input logic en_n, input logic oe,
                            input logic [7:0] dout, input logic [1:0] gnt,
                            input logic conf, input logic [7:0] cnt);
        chk({tag, " en245_n"},      16'(en245_n),      16'(en_n));
        chk({tag, " data_oe"},      16'(data_oe),      16'(oe));
        chk({tag, " data_out"},     16'(data_out),     16'(dout));
        chk({tag, " grant"},        16'(grant),        16'(gnt));
        chk({tag, " conflict"},     16'(conflict),     16'(conf));
        chk({tag, " conflict_cnt"}, 16'(conflict_cnt), 16'(cnt));
    endtask

    // ------------------------------------------------------------------
    // Directed phase table: pins {rom_sel_n, dev_sel_n, rw, addr0} held for
    // 'hold' cycles, then outputs must match the recorded values.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] pins;
        int         hold;
        logic       en_n;
        logic       oe;
        logic [7:0] dout;
        logic [1:0] gnt;
        logic       conf;
        logic [7:0] cnt;
    } vec_t;

    function automatic vec_t v(input logic [3:0] pins, input int hold, input logic [1:0] eo,
                               input logic [7:0] dout, input logic [1:0] gnt,
                               input logic conf, input logic [7:0] cnt);
        vec_t r;
        r.pins = pins; r.hold = hold; r.en_n = eo[1]; r.oe = eo[0];
        r.dout = dout; r.gnt = gnt; r.conf = conf; r.cnt = cnt;
        return r;
    endfunction

    vec_t tbl[22];

    initial begin
        // ROM read: SETTLE after 3 edges, DRIVE after 5, release after 3
        tbl[0]  = v(4'b0110, 4, 2'b10, 8'hA5, 2'b01, 1'b0, 8'd0);
        tbl[1]  = v(4'b0110, 1, 2'b01, 8'hA5, 2'b01, 1'b0, 8'd0);
        tbl[2]  = v(4'b0110, 5, 2'b01, 8'hA5, 2'b01, 1'b0, 8'd0);
        tbl[3]  = v(4'b1110, 2, 2'b01, 8'hA5, 2'b01, 1'b0, 8'd0);
        tbl[4]  = v(4'b1110, 1, 2'b10, 8'hA5, 2'b00, 1'b0, 8'd0);
        tbl[5]  = v(4'b1110, 2, 2'b10, 8'h00, 2'b00, 1'b0, 8'd0);
        // IWM read, then addr0 = 1, then write
        tbl[6]  = v(4'b1010, 5, 2'b01, 8'h3C, 2'b10, 1'b0, 8'd0);
        tbl[7]  = v(4'b1011, 3, 2'b00, 8'h3C, 2'b10, 1'b0, 8'd0);
        tbl[8]  = v(4'b1000, 3, 2'b00, 8'h3C, 2'b10, 1'b0, 8'd0);
        tbl[9]  = v(4'b1110, 5, 2'b10, 8'h00, 2'b00, 1'b0, 8'd0);
        // Simultaneous selects for one cycle
        tbl[10] = v(4'b0010, 1, 2'b10, 8'h00, 2'b00, 1'b0, 8'd0);
        tbl[11] = v(4'b1110, 2, 2'b10, 8'h00, 2'b00, 1'b1, 8'd1);
        tbl[12] = v(4'b1110, 1, 2'b10, 8'h00, 2'b00, 1'b0, 8'd1);
        // One-cycle ROM glitch: SETTLE then abort to TURN
        tbl[13] = v(4'b0110, 1, 2'b10, 8'h00, 2'b00, 1'b0, 8'd1);
        tbl[14] = v(4'b1110, 2, 2'b10, 8'hA5, 2'b01, 1'b0, 8'd1);
        tbl[15] = v(4'b1110, 1, 2'b10, 8'hA5, 2'b00, 1'b0, 8'd1);
        tbl[16] = v(4'b1110, 2, 2'b10, 8'h00, 2'b00, 1'b0, 8'd1);
        // ROM driving, IWM select overlaps, then IWM takes over
        tbl[17] = v(4'b0110, 5, 2'b01, 8'hA5, 2'b01, 1'b0, 8'd1);
        tbl[18] = v(4'b0010, 3, 2'b10, 8'hA5, 2'b00, 1'b1, 8'd2);
        tbl[19] = v(4'b1010, 2, 2'b10, 8'h00, 2'b00, 1'b0, 8'd2);
        tbl[20] = v(4'b1010, 1, 2'b10, 8'h3C, 2'b10, 1'b0, 8'd2);
        tbl[21] = v(4'b1010, 2, 2'b01, 8'h3C, 2'b10, 1'b0, 8'd2);
    end

    initial begin
        rom_data = 8'hA5;
        iwm_data = 8'h3C;

        // Reset state
        reset = 1'b1;
        step();
        step();
        chk_outs("reset", 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'd0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            {rom_sel_n, dev_sel_n, rw, addr0} = tbl[i].pins;
            repeat (tbl[i].hold) step();
            chk_outs($sformatf("row%0d", i), tbl[i].en_n, tbl[i].oe, tbl[i].dout,
                     tbl[i].gnt, tbl[i].conf, tbl[i].cnt);
        end

        // Reset while IWM is driving
        dev_sel_n = 1'b1;
        reset     = 1'b1;
        step();
        chk_outs("reset_in_drive", 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'd0);
        reset = 1'b0;
        step();

        // Hold both selects to saturate the conflict counter
        rom_sel_n = 1'b0;
        dev_sel_n = 1'b0;
        repeat (300) step();
        chk_outs("saturate", 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'd255);
        rom_sel_n = 1'b1;
        dev_sel_n = 1'b1;
        repeat (4) step();
        chk_outs("saturate_hold", 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'd255);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) rom_sel_n = ~rom_sel_n;
            if ($urandom_range(0, 7) == 0) dev_sel_n = ~dev_sel_n;
            if ($urandom_range(0, 3) == 0) rw = ~rw;
            if ($urandom_range(0, 3) == 0) addr0 = ~addr0;
            rom_data = 8'($urandom);
            iwm_data = 8'($urandom);
            reset    = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
